spi_pkt_sched: RTL and testbench
================================

Name: spi_pkt_sched

Overview:
- Clock-domain controller that feeds and drains the DClk-domain SPI slave shifter.
- Watches the shifter's TxGetNext and PktComplete toggles and supplies the next 128-bit transmit packet. Sources, in priority order: a pending command response, then the trace stream, then an idle filler.
- Decodes each received 32-bit frame as a host command that writes a config register or requests a status response.
- Sits between the trace packetiser/FIFO and the spi block, in the system clk domain.

Parameters:
- IDLE_PKT, 128'hA5A5_..._A5A5 (all bytes 8'hA5): filler packet sent when nothing is queued.
- CFG_RESET, 16'h0000: reset value of cfg.
- SYNC_STAGES, 2: flip-flop stages in each toggle synchroniser (legal values 2..3).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- TxGetNext  in  1  toggle from spi; each edge is a request for the next packet (async to clk).
- PktComplete  in  1  toggle from spi; each edge means RxedFrame is valid (async to clk).
- RxedFrame  in  32  received command frame; stable for at least 90 DClk periods after a PktComplete edge.
- Tx_packet  out  128  packet presented to spi; must be stable before spi loads it.
- trace_data  in  128  trace packet from upstream.
- trace_valid  in  1  trace_data is valid.
- trace_ready  out  1  single-cycle accept pulse; trace_data is consumed when trace_valid && trace_ready.
- status  in  32  live status word, sampled when a status response is built.
- cfg  out  16  host-written configuration register.
- cfg_strobe  out  1  one-cycle pulse when cfg is written.
- resp_ovf  out  8  count of dropped status requests; saturates at 8'hFF.

Behaviour:
- Synchroniser: TxGetNext and PktComplete each pass through SYNC_STAGES flops into prev-registers. An edge is detected when sync != prev.
  - During rst, prev is loaded from the sync output, so no spurious edge appears at reset release.
- Reset values: Tx_packet=IDLE_PKT, trace_ready=0, cfg=CFG_RESET, cfg_strobe=0, resp_ovf=0, resp_pend=0, FSM=IDLE.
- Tx FSM:
  - IDLE: on a TxGetNext edge, go to SEL.
  - SEL (one cycle): choose and load the packet, then return to IDLE.
    - resp_pend=1: Tx_packet<=resp_pkt; clear resp_pend.
    - else trace_valid=1: Tx_packet<=trace_data; trace_ready=1 for this cycle only.
    - else: Tx_packet<=IDLE_PKT.
  - Latency: Tx_packet is updated no later than SYNC_STAGES+2 clk cycles after the raw toggle edge. clk must be at least 1/16 of the DClk rate so the load completes inside spi's 95-DClk window.
  - trace_ready is never asserted outside SEL.
  - A second TxGetNext edge that arrives while in SEL is caught by the prev-register compare on the next IDLE cycle, so it is not lost.
- Rx decode: on a PktComplete edge, RxedFrame is sampled that cycle. The opcode is RxedFrame[31:24].
  - 8'h00 NOP: no action.
  - 8'h01 WRCFG: cfg<=RxedFrame[15:0]; cfg_strobe=1 for the next cycle.
  - 8'h02 RDSTAT:
    - If resp_pend=0: resp_pkt<={8'hC0, RxedFrame[23:0], 32'h0, 32'h0, status}; set resp_pend.
    - If resp_pend=1: discard the request and increment resp_ovf (saturating).
  - Any other opcode is ignored, with no counter change.
- Simultaneous events: if a RDSTAT decode and a SEL fall in the same cycle, SEL uses the pre-update resp_pend. The new response is sent on the following request. Clearing and setting resp_pend in the same cycle resolves to set.
- rst mid-transfer: all state returns to reset values. Tx_packet=IDLE_PKT immediately on the next clk edge, and any pending response is lost.

Decomposition:
- Package spi_pkg:
  - opcode constants OP_NOP, OP_WRCFG, OP_RDSTAT.
  - RESP_HDR=8'hC0.
  - FSM state typedef {IDLE, SEL}.
  - widths PKT_W=128, FRAME_W=32.
- Sub-module toggle_sync:
  - SYNC_STAGES-flop synchroniser plus prev-register and edge output, with rst preload.
  - Instantiated twice.

Test Plan:
1. Reset release with TxGetNext=1 and PktComplete=1 held -> no SEL and no decode; Tx_packet=IDLE_PKT, cfg=16'h0000, resp_ovf=0.
2. trace_valid=1 with trace_data=128'h0123...CDEF, then toggle TxGetNext -> trace_ready pulses for exactly one cycle and Tx_packet=128'h0123...CDEF within 4 clk cycles. Toggle again with trace_valid=0 -> Tx_packet=IDLE_PKT.
3. PktComplete edge with RxedFrame=32'h0100_BEEF -> cfg=16'hBEEF and cfg_strobe high for exactly one cycle.
4. RxedFrame=32'h0212_3456 with status=32'hDEAD_0001, then a TxGetNext edge while trace_valid=1 -> Tx_packet={8'hC0, 24'h123456, 64'h0, 32'hDEAD0001}, trace_ready stays 0. The next request sends the trace packet.
5. Three RDSTAT frames with no intervening TxGetNext -> resp_ovf=2 and the first response is preserved. Preload resp_ovf=255 and repeat -> resp_ovf stays 255.
6. A PktComplete RDSTAT edge and a TxGetNext edge aligned to the same clk cycle -> the first packet is trace/idle and the second is the response. Assert rst while resp_pend=1 -> resp_pend=0 and Tx_packet=IDLE_PKT.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI packet scheduler: opcodes, response
// header, widths and the transmit FSM state type.
package spi_pkg;

   localparam int PKT_W   = 128;
   localparam int FRAME_W = 32;

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_WRCFG  = 8'h01;
   localparam logic [7:0] OP_RDSTAT = 8'h02;
   localparam logic [7:0] RESP_HDR  = 8'hC0;

   typedef enum logic {
      IDLE = 1'b0,
      SEL  = 1'b1
   } tx_state_t;

endpackage

// File: rtl/toggle_sync.sv
// Toggle-to-edge synchroniser. The prev register only follows the synchronised
// level while 'take' is high, so an edge is held pending until it is consumed.
module toggle_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic tog,
   input  logic take,
   output logic toggled
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // The chain keeps sampling through reset so prev can be preloaded with the
   // settled level, which suppresses a spurious edge at reset release.
   always_ff @(posedge clk) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog};
      if (rst || take) begin
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign toggled = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/spi_pkt_sched.sv
// Supplies transmit packets to the DClk-domain SPI shifter (response > trace >
// idle filler) and decodes received host command frames.
module spi_pkt_sched
   import spi_pkg::*;
#(
   parameter logic [PKT_W-1:0] IDLE_PKT    = {16{8'hA5}},
   parameter logic [15:0]      CFG_RESET   = 16'h0000,
   parameter int               SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               TxGetNext,
   input  logic               PktComplete,
   input  logic [FRAME_W-1:0] RxedFrame,
   output logic [PKT_W-1:0]   Tx_packet,
   input  logic [PKT_W-1:0]   trace_data,
   input  logic               trace_valid,
   output logic               trace_ready,
   input  logic [31:0]        status,
   output logic [15:0]        cfg,
   output logic               cfg_strobe,
   output logic [7:0]         resp_ovf
);

   tx_state_t          state, state_nxt;
   logic               tx_toggled, rx_toggled;
   logic               resp_pend;
   logic [PKT_W-1:0]   resp_pkt;
   logic [7:0]         opcode;
   logic               wr_cfg, rd_stat;

   toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tx_sync (
      .clk     (clk),
      .rst     (rst),
      .tog     (TxGetNext),
      .take    (state == IDLE),
      .toggled (tx_toggled)
   );

   toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rx_sync (
      .clk     (clk),
      .rst     (rst),
      .tog     (PktComplete),
      .take    (1'b1),
      .toggled (rx_toggled)
   );

   assign opcode  = RxedFrame[31:24];
   assign wr_cfg  = rx_toggled && (opcode == OP_WRCFG);
   assign rd_stat = rx_toggled && (opcode == OP_RDSTAT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      trace_ready = 1'b0;
      case (state)
         IDLE: if (tx_toggled) state_nxt = SEL;
         SEL: begin
            state_nxt   = IDLE;
            trace_ready = !resp_pend && trace_valid;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Tx_packet  <= IDLE_PKT;
         cfg        <= CFG_RESET;
         cfg_strobe <= 1'b0;
         resp_ovf   <= 8'h00;
         resp_pend  <= 1'b0;
         resp_pkt   <= '0;
      end else begin
         cfg_strobe <= wr_cfg;
         if (wr_cfg) begin
            cfg <= RxedFrame[15:0];
         end

         if (state == SEL) begin
            if (resp_pend) begin
               Tx_packet <= resp_pkt;
            end else if (trace_valid) begin
               Tx_packet <= trace_data;
            end else begin
               Tx_packet <= IDLE_PKT;
            end
         end

         // SEL and decode both see the pre-update resp_pend; a set wins.
         if (rd_stat && !resp_pend) begin
            resp_pkt  <= {RESP_HDR, RxedFrame[23:0], 64'h0, status};
            resp_pend <= 1'b1;
         end else if (state == SEL) begin
            resp_pend <= 1'b0;
         end

         if (rd_stat && resp_pend && (resp_ovf != 8'hFF)) begin
            resp_ovf <= resp_ovf + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_spi_pkt_sched.sv
// Bench for spi_pkt_sched: table-driven command frames, directed corner-case
// sequences and random traffic checked against a transaction-level model.
module tb_spi_pkt_sched;

   localparam logic [127:0] IDLE_PKT = {16{8'hA5}};
   localparam logic [127:0] TD1 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] TD2 = 128'hFEDCBA98765432100011223344556677;
   localparam logic [127:0] TD3 = 128'h13579BDF2468ACE0CAFEF00DDEADBEEF;

   logic         clk = 1'b0;
   logic         rst;
   logic         TxGetNext, PktComplete;
   logic [31:0]  RxedFrame, status;
   logic [127:0] Tx_packet, trace_data;
   logic         trace_valid, trace_ready;
   logic [15:0]  cfg;
   logic         cfg_strobe;
   logic [7:0]   resp_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   // transaction-level model state
   logic [15:0]  m_cfg;
   logic         m_pend;
   logic [127:0] m_resp;
   int           m_ovf;

   spi_pkt_sched dut (
      .clk         (clk),
      .rst         (rst),
      .TxGetNext   (TxGetNext),
      .PktComplete (PktComplete),
      .RxedFrame   (RxedFrame),
      .Tx_packet   (Tx_packet),
      .trace_data  (trace_data),
      .trace_valid (trace_valid),
      .trace_ready (trace_ready),
      .status      (status),
      .cfg         (cfg),
      .cfg_strobe  (cfg_strobe),
      .resp_ovf    (resp_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      m_cfg  = 16'h0000;
      m_pend = 1'b0;
      m_resp = '0;
      m_ovf  = 0;
   endtask

   task automatic model_rx(input logic [31:0] f, input logic [31:0] st);
      case (f[31:24])
         8'h01: m_cfg = f[15:0];
         8'h02: begin
            if (!m_pend) begin
               m_resp = {8'hC0, f[23:0], 64'h0, st};
               m_pend = 1'b1;
            end else if (m_ovf < 255) begin
               m_ovf++;
            end
         end
         default: ;
      endcase
   endtask

   task automatic model_tx(input logic tv, input logic [127:0] td,
                           output logic [127:0] pkt, output int rdy);
      rdy = 0;
      if (m_pend) begin
         pkt    = m_resp;
         m_pend = 1'b0;
      end else if (tv) begin
         pkt = td;
         rdy = 1;
      end else begin
         pkt = IDLE_PKT;
      end
   endtask

   // Called right after a negedge; leaves the bench on a negedge.
   task automatic rx_drive(input logic [31:0] f, input logic [31:0] st, output int strb);
      RxedFrame   = f;
      status      = st;
      PktComplete = ~PktComplete;
      strb = 0;
      repeat (5) begin
         @(negedge clk);
         if (cfg_strobe) strb++;
      end
   endtask

   task automatic rx_req(input logic [31:0] f, input logic [31:0] st);
      int s;
      rx_drive(f, st, s);
      model_rx(f, st);
      check("cfg", cfg, m_cfg);
      check("cfg_strobe_cycles", s, (f[31:24] == 8'h01) ? 1 : 0);
      check("resp_ovf", resp_ovf, m_ovf);
   endtask

   task automatic tx_req(input logic tv, input logic [127:0] td);
      logic [127:0] e;
      int er, r;
      model_tx(tv, td, e, er);
      r = 0;
      trace_valid = tv;
      trace_data  = td;
      TxGetNext   = ~TxGetNext;
      repeat (4) begin
         @(negedge clk);
         if (trace_ready) r++;
      end
      check("tx_packet_latency", Tx_packet, e);
      repeat (2) begin
         @(negedge clk);
         if (trace_ready) r++;
      end
      trace_valid = 1'b0;
      check("trace_ready_cycles", r, er);
   endtask

   typedef struct {
      logic [31:0] frame;
      logic [15:0] exp_cfg;
      int          exp_strb;
      logic [7:0]  exp_ovf;
   } rx_vec_t;

   initial begin
      rx_vec_t vecs[6];
      logic [127:0] e;
      int er, r, s;

      // 1: reset release with both toggles held high and a RDSTAT frame present
      rst = 1'b1; TxGetNext = 1'b1; PktComplete = 1'b1;
      RxedFrame = 32'h0200_0000; status = 32'h0;
      trace_valid = 1'b1; trace_data = TD1;
      model_reset();
      repeat (5) @(negedge clk);
      rst = 1'b0;
      r = 0; s = 0;
      repeat (6) begin
         @(negedge clk);
         if (trace_ready) r++;
         if (cfg_strobe) s++;
      end
      trace_valid = 1'b0;
      check("rst_trace_ready", r, 0);
      check("rst_cfg_strobe", s, 0);
      check("rst_tx_packet", Tx_packet, IDLE_PKT);
      check("rst_cfg", cfg, 16'h0000);
      check("rst_resp_ovf", resp_ovf, 8'h00);
      tx_req(1'b0, TD1);

      // 2: trace packet then idle filler
      tx_req(1'b1, TD1);
      check("trace_pkt", Tx_packet, TD1);
      tx_req(1'b0, TD2);
      check("idle_pkt", Tx_packet, IDLE_PKT);

      // 3: command frame table
      vecs[0] = '{32'h0100_BEEF, 16'hBEEF, 1, 8'h00};
      vecs[1] = '{32'h0000_1234, 16'hBEEF, 0, 8'h00};
      vecs[2] = '{32'h7F00_5555, 16'hBEEF, 0, 8'h00};
      vecs[3] = '{32'h01FF_0001, 16'h0001, 1, 8'h00};
      vecs[4] = '{32'hFF00_9999, 16'h0001, 0, 8'h00};
      vecs[5] = '{32'h0100_BEEF, 16'hBEEF, 1, 8'h00};
      for (int i = 0; i < 6; i++) begin
         rx_drive(vecs[i].frame, 32'h0, s);
         model_rx(vecs[i].frame, 32'h0);
         check("vec_cfg", cfg, vecs[i].exp_cfg);
         check("vec_strobe_cycles", s, vecs[i].exp_strb);
         check("vec_resp_ovf", resp_ovf, vecs[i].exp_ovf);
      end

      // 4: response beats trace
      rx_req(32'h0212_3456, 32'hDEAD_0001);
      tx_req(1'b1, TD2);
      check("resp_pkt", Tx_packet, {8'hC0, 24'h123456, 64'h0, 32'hDEAD_0001});
      tx_req(1'b1, TD2);
      check("trace_after_resp", Tx_packet, TD2);

      // 5: dropped requests and saturation
      rx_req(32'h0200_0001, 32'h1111_1111);
      rx_req(32'h0200_0002, 32'h2222_2222);
      rx_req(32'h0200_0003, 32'h3333_3333);
      check("ovf_two", resp_ovf, 8'd2);
      tx_req(1'b0, TD1);
      check("first_resp_kept", Tx_packet, {8'hC0, 24'h000001, 64'h0, 32'h1111_1111});
      rx_req(32'h0200_0004, 32'h4444_4444);
      for (int i = 0; i < 255; i++) rx_req(32'h0200_0005, 32'h5555_5555);
      check("ovf_saturated", resp_ovf, 8'hFF);
      tx_req(1'b0, TD1);

      // 6: RDSTAT decode lands in the same cycle as SEL
      model_tx(1'b1, TD3, e, er);
      r = 0;
      trace_valid = 1'b1; trace_data = TD3;
      TxGetNext = ~TxGetNext;
      @(negedge clk);
      if (trace_ready) r++;
      RxedFrame = 32'h02AB_CDEF; status = 32'h0BAD_F00D;
      PktComplete = ~PktComplete;
      model_rx(32'h02AB_CDEF, 32'h0BAD_F00D);
      repeat (3) begin
         @(negedge clk);
         if (trace_ready) r++;
      end
      check("coincident_first", Tx_packet, e);
      repeat (3) begin
         @(negedge clk);
         if (trace_ready) r++;
      end
      trace_valid = 1'b0;
      check("coincident_ready_cycles", r, er);
      tx_req(1'b1, TD3);
      check("coincident_second", Tx_packet, {8'hC0, 24'hABCDEF, 64'h0, 32'h0BAD_F00D});

      // random traffic
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 4))
            0: rx_req({8'h01, 8'($urandom), 16'($urandom)}, $urandom);
            1: rx_req({8'h02, 24'($urandom)}, $urandom);
            2: rx_req({8'($urandom_range(3, 255)), 24'($urandom)}, $urandom);
            default: tx_req(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
         endcase
      end

      // rst while a response is pending
      rx_req(32'h0100_1234, 32'h0);
      if (!m_pend) rx_req(32'h0277_7777, 32'h7777_7777);
      tx_req(1'b1, TD1);
      rx_req(32'h0266_6666, 32'h6666_6666);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("midrst_tx_packet", Tx_packet, IDLE_PKT);
      check("midrst_cfg", cfg, 16'h0000);
      check("midrst_resp_ovf", resp_ovf, 8'h00);
      tx_req(1'b0, TD2);
      check("midrst_resp_lost", Tx_packet, IDLE_PKT);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
